// File: rtl/superscalar_issue_scoreboard.sv
// Clocked issue scoreboard for the 3-wide core: per-register result countdowns plus
// in-order intra-bundle RAW/WAW resolution, producing per-lane issue/stall and sequence numbers.
module superscalar_issue_scoreboard #(
  parameter int NUM_LANES = 3,
  parameter int REG_W     = 5,
  parameter int ALU_LAT   = 1,
  parameter int MEM_LAT   = 2,
  parameter int SEQ_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [NUM_LANES-1:0]         lane_valid,
  input  logic [NUM_LANES*REG_W-1:0]   lane_dest,
  input  logic [NUM_LANES*REG_W-1:0]   lane_src1,
  input  logic [NUM_LANES*REG_W-1:0]   lane_src2,
  input  logic [NUM_LANES*3-1:0]       lane_use,
  input  logic [NUM_LANES-1:0]         lane_is_load,
  output logic [NUM_LANES-1:0]         issue,
  output logic [NUM_LANES-1:0]         stall,
  output logic [NUM_LANES*SEQ_W-1:0]   issue_seq,
  output logic [SEQ_W-1:0]             seq_next
);

  localparam int NREG    = 2**REG_W;
  localparam int MAX_LAT = (ALU_LAT > MEM_LAT) ? ALU_LAT : MEM_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;
  localparam logic [CNT_W-1:0] ALU_SET = CNT_W'(ALU_LAT - 1);
  localparam logic [CNT_W-1:0] MEM_SET = CNT_W'(MEM_LAT - 1);

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [SEQ_W-1:0] seq_next_q, seq_next_d;
  logic [NREG-1:0]  busy;

  logic [REG_W-1:0] dst [NUM_LANES];
  logic [REG_W-1:0] s1  [NUM_LANES];
  logic [REG_W-1:0] s2  [NUM_LANES];
  logic [NUM_LANES-1:0] wr, rd1, rd2, hz;
  logic             older_ok;
  logic [SEQ_W-1:0] seq_run;

  always_comb begin
    for (int k = 0; k < NUM_LANES; k++) begin
      dst[k] = lane_dest[k*REG_W +: REG_W];
      s1[k]  = lane_src1[k*REG_W +: REG_W];
      s2[k]  = lane_src2[k*REG_W +: REG_W];
      wr[k]  = lane_use[k*3 + 2];
      rd1[k] = lane_use[k*3 + 1];
      rd2[k] = lane_use[k*3];
    end
  end

  // Register 0 is forced idle so a stray write to it can never stall anyone.
  always_comb begin
    busy = '0;
    for (int r = 1; r < NREG; r++) busy[r] = (cnt_q[r] != '0);
  end

  // Hazards see only pre-edge counters; older lanes block younger ones in the same bundle.
  always_comb begin
    hz = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if ((rd1[k] && busy[s1[k]]) || (rd2[k] && busy[s2[k]]) || (wr[k] && busy[dst[k]]))
        hz[k] = 1'b1;
      for (int j = 0; j < NUM_LANES; j++) begin
        if (j < k && lane_valid[j] && wr[j] && dst[j] != '0 &&
            ((rd1[k] && s1[k] == dst[j]) || (rd2[k] && s2[k] == dst[j]) ||
             (wr[k] && dst[k] == dst[j])))
          hz[k] = 1'b1;
      end
    end
  end

  always_comb begin
    issue     = '0;
    stall     = '0;
    issue_seq = '0;
    older_ok  = 1'b1;
    seq_run   = seq_next_q;
    if (rst_n && !flush) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        issue[k] = lane_valid[k] & ~hz[k] & older_ok;
        older_ok = older_ok & (issue[k] | ~lane_valid[k]);
        issue_seq[k*SEQ_W +: SEQ_W] = seq_run;
        seq_run = seq_run + SEQ_W'(issue[k]);
      end
      stall = lane_valid & ~issue;
    end
    seq_next_d = seq_run;
  end

  // A fresh set beats the decrement of the same register.
  always_comb begin
    for (int r = 0; r < NREG; r++)
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CNT_W'(1) : '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (issue[k] && wr[k] && dst[k] != '0)
        cnt_d[dst[k]] = lane_is_load[k] ? MEM_SET : ALU_SET;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      seq_next_q <= '0;
    end else if (flush) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      seq_next_q <= seq_next_d;
    end
  end

  assign seq_next = seq_next_q;

endmodule

// File: tb/tb_superscalar_issue_scoreboard.sv
// Scoreboard bench: a driver queues hand-computed expectations per cycle, a monitor pops and compares.
module tb_superscalar_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n, flush;
  logic [2:0]  lane_valid, lane_is_load;
  logic [14:0] lane_dest, lane_src1, lane_src2;
  logic [8:0]  lane_use;
  logic [2:0]  issue, stall;
  logic [47:0] issue_seq;
  logic [15:0] seq_next;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [2:0]  iss;
    logic [2:0]  stl;
    logic [15:0] sn;
  } exp_t;
  exp_t expq[$];

  superscalar_issue_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .lane_valid(lane_valid), .lane_dest(lane_dest), .lane_src1(lane_src1),
    .lane_src2(lane_src2), .lane_use(lane_use), .lane_is_load(lane_is_load),
    .issue(issue), .stall(stall), .issue_seq(issue_seq), .seq_next(seq_next)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] R(input int a, input int b, input int c);
    return {5'(c), 5'(b), 5'(a)};
  endfunction

  function automatic logic [8:0] U(input int a, input int b, input int c);
    return {3'(c), 3'(b), 3'(a)};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic step(input string name, input logic rn, input logic fl, input logic [2:0] v,
                      input logic [14:0] d, input logic [14:0] a, input logic [14:0] b,
                      input logic [8:0] u, input logic [2:0] ld,
                      input logic [2:0] ei, input logic [2:0] es, input logic [15:0] esn);
    exp_t e;
    rst_n = rn; flush = fl; lane_valid = v; lane_dest = d;
    lane_src1 = a; lane_src2 = b; lane_use = u; lane_is_load = ld;
    e.name = name; e.iss = ei; e.stl = es; e.sn = esn;
    expq.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin : monitor
    exp_t e;
    logic [15:0] s;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk({e.name, ".issue"}, 32'(issue), 32'(e.iss));
        chk({e.name, ".stall"}, 32'(stall), 32'(e.stl));
        chk({e.name, ".seq_next"}, 32'(seq_next), 32'(e.sn));
        s = e.sn;
        for (int k = 0; k < 3; k++) begin
          if (e.iss[k]) begin
            chk($sformatf("%s.issue_seq%0d", e.name, k), 32'(issue_seq[k*16 +: 16]), 32'(s));
            s = s + 16'd1;
          end
        end
      end
    end
  end

  initial begin : driver
    int wait_cyc;
    rst_n = 1'b0; flush = 1'b0; lane_valid = '0; lane_dest = '0;
    lane_src1 = '0; lane_src2 = '0; lane_use = '0; lane_is_load = '0;
    repeat (2) @(posedge clk);
    #1;
    step("rst_hold",  0, 0, 3'b111, R(1,2,3), R(4,6,8), R(5,7,9), U(7,7,7), 3'b000, 3'b000, 3'b000, 16'd0);
    step("indep",     1, 0, 3'b111, R(1,2,3), R(4,6,8), R(5,7,9), U(7,7,7), 3'b000, 3'b111, 3'b000, 16'd0);
    step("lw_r5",     1, 0, 3'b001, R(5,0,0), R(10,0,0), R(0,0,0), U(6,0,0), 3'b001, 3'b001, 3'b000, 16'd3);
    step("use_r5_st", 1, 0, 3'b001, R(6,0,0), R(5,0,0), R(7,0,0), U(7,0,0), 3'b000, 3'b000, 3'b001, 16'd4);
    step("use_r5_go", 1, 0, 3'b001, R(6,0,0), R(5,0,0), R(7,0,0), U(7,0,0), 3'b000, 3'b001, 3'b000, 16'd4);
    step("intra_raw", 1, 0, 3'b111, R(8,9,10), R(1,8,11), R(2,3,12), U(7,7,7), 3'b000, 3'b001, 3'b110, 16'd5);
    step("intra_rest",1, 0, 3'b110, R(8,9,10), R(1,8,11), R(2,3,12), U(7,7,7), 3'b000, 3'b110, 3'b000, 16'd6);
    step("r0_write",  1, 0, 3'b011, R(0,13,0), R(1,0,0), R(2,0,0), U(7,7,0), 3'b001, 3'b011, 3'b000, 16'd8);
    step("r0_read",   1, 0, 3'b001, R(14,0,0), R(0,0,0), R(0,0,0), U(7,0,0), 3'b000, 3'b001, 3'b000, 16'd10);
    // 21841 full bundles move seq_next from 11 to 0xFFFE
    rst_n = 1'b1; flush = 1'b0; lane_valid = 3'b111; lane_dest = R(1,2,3);
    lane_src1 = R(4,6,8); lane_src2 = R(5,7,9); lane_use = U(7,7,7); lane_is_load = 3'b000;
    repeat (21841) @(posedge clk);
    #1;
    step("wrap",      1, 0, 3'b111, R(1,2,3), R(4,6,8), R(5,7,9), U(7,7,7), 3'b000, 3'b111, 3'b000, 16'hFFFE);
    step("lw_r5_b",   1, 0, 3'b001, R(5,0,0), R(10,0,0), R(0,0,0), U(6,0,0), 3'b001, 3'b001, 3'b000, 16'd1);
    step("flush",     1, 1, 3'b001, R(6,0,0), R(5,0,0), R(7,0,0), U(7,0,0), 3'b000, 3'b000, 3'b000, 16'd2);
    step("post_flush",1, 0, 3'b001, R(6,0,0), R(5,0,0), R(7,0,0), U(7,0,0), 3'b000, 3'b001, 3'b000, 16'd2);
    step("lw_r5_c",   1, 0, 3'b001, R(5,0,0), R(10,0,0), R(0,0,0), U(6,0,0), 3'b001, 3'b001, 3'b000, 16'd3);
    step("mid_rst",   0, 0, 3'b001, R(6,0,0), R(5,0,0), R(7,0,0), U(7,0,0), 3'b000, 3'b000, 3'b000, 16'd4);
    step("post_rst",  1, 0, 3'b001, R(6,0,0), R(5,0,0), R(7,0,0), U(7,0,0), 3'b000, 3'b001, 3'b000, 16'd0);
    step("lw_r20",    1, 0, 3'b001, R(20,0,0), R(10,0,0), R(0,0,0), U(6,0,0), 3'b001, 3'b001, 3'b000, 16'd1);
    step("waw_stall", 1, 0, 3'b011, R(20,21,0), R(1,1,0), R(2,2,0), U(7,7,0), 3'b000, 3'b000, 3'b011, 16'd2);
    step("waw_go",    1, 0, 3'b011, R(20,21,0), R(1,1,0), R(2,2,0), U(7,7,0), 3'b000, 3'b011, 3'b000, 16'd2);
    step("inv_older", 1, 0, 3'b010, R(22,23,0), R(1,22,0), R(2,1,0), U(7,7,0), 3'b000, 3'b010, 3'b000, 16'd4);
    lane_valid = '0;
    wait_cyc = 0;
    while (expq.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (expq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/superscalar_issue_scoreboard.md
Name: superscalar_issue_scoreboard

Overview:
- Parametrised, clocked successor to the combinational decode-hazard check of the 3-wide superscalar core.
- Sits between the per-lane IF/ID registers and ID/EX. Tracks per-register result-ready countdowns across cycles, and resolves intra-bundle RAW/WAW hazards in program order.
- Produces a per-lane issue/stall mask and a per-lane sequence number.
- Replaces the ad-hoc "stall = 2" with latency-exact scoreboarding.

Parameters:
- NUM_LANES, 3, lanes per bundle; lane 0 is oldest in program order.
- REG_W, 5, register-address width (2**REG_W architectural registers; register 0 is hardwired zero).
- ALU_LAT, 1, cycles from ALU issue until the result is forwardable.
- MEM_LAT, 2, cycles from load issue until the result is forwardable.
- SEQ_W, 16, sequence-number width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  discard the in-flight bundle and clear the scoreboard.
- lane_valid  in  NUM_LANES  lane k holds a decoded instruction.
- lane_dest  in  NUM_LANES*REG_W  destination register per lane.
- lane_src1  in  NUM_LANES*REG_W  source 1 per lane.
- lane_src2  in  NUM_LANES*REG_W  source 2 per lane.
- lane_use  in  NUM_LANES*3  per lane {writes_dest, reads_src1, reads_src2}.
- lane_is_load  in  NUM_LANES  destination latency is MEM_LAT (else ALU_LAT).
- issue  out  NUM_LANES  lane k issues this cycle (combinational).
- stall  out  NUM_LANES  lane_valid[k] & ~issue[k]; ID/EX for lane k receives NOP.
- issue_seq  out  NUM_LANES*SEQ_W  sequence number of lane k; meaningful only when issue[k].
- seq_next  out  SEQ_W  registered global sequence counter.

Behaviour:
- Scoreboard
  - One down-counter per register, width clog2(max(ALU_LAT,MEM_LAT))+1.
  - A register is busy when its counter is nonzero. Register 0 is never busy and never written.
- Lane k hazard (combinational from current inputs and registered counters)
  - src_hz: a read source is busy.
  - dst_hz: writes_dest and dest is busy (WAW).
  - intra_hz: an older valid lane j<k in the same bundle has writes_dest with dest equal to any used src or dest of lane k (dest != 0).
- issue[k] = lane_valid[k] & ~src_hz & ~dst_hz & ~intra_hz & (issue[j] or ~lane_valid[j] for all j<k). In-order issue: once a lane stalls, every younger lane stalls.
- flush=1: issue=0, stall=0 that cycle regardless of inputs.
- Clock edge, when issue[k] and writes_dest and dest!=0: counter[dest] <= LAT-1, where LAT = MEM_LAT if is_load else ALU_LAT. With LAT=1 this leaves the counter at 0, i.e. full forwarding and no stall.
- Every other nonzero counter decrements by 1 per cycle. Setting a counter takes priority over decrementing it.
- Two lanes cannot set the same register in one cycle, because intra_hz forbids it.
- Sequence numbering
  - issue_seq[k] = seq_next + (number of issued lanes j<k), modulo 2**SEQ_W.
  - seq_next advances by popcount(issue) each edge and wraps modulo 2**SEQ_W without a flag.
- Upstream protocol: upstream clears lane_valid for issued lanes next cycle and re-presents stalled lanes unchanged. This block holds no bundle state.
- Flush edge: all counters <= 0. seq_next is kept.
- Reset edge (rst_n=0): all counters <= 0, seq_next <= 0.
  - While rst_n=0: issue=0, stall=0.
  - Reset mid-countdown discards all pending state; the first post-reset bundle sees no busy registers.
- Boundary cases
  - lane_valid=0: lane ignored; it never causes intra_hz.
  - dest=0 with writes_dest: no scoreboard effect, no intra_hz.
  - Hazard checks use pre-edge counters only; there is no same-cycle bypass of set values.

Test Plan:
- Reset, then lanes 0-2 valid with independent regs (dest 1,2,3; srcs 4-9), ALU -> issue=3'b111, issue_seq=0,1,2, seq_next=3 after the edge.
- Lane 0 "lw r5" issued; next cycle lane 0 "add r6,r5,r7" -> stall[0]=1 for exactly 1 cycle (MEM_LAT=2), issues on the second cycle with seq=1.
- Same bundle: lane0 add r8←..., lane1 sub uses r8, lane2 independent -> issue=3'b001; lanes 1 and 2 stall (in-order); next cycle issue=3'b110.
- Lane0 writes r0, lane1 reads r0 -> issue=3'b011; no counter changes.
- seq_next preloaded near wrap via 0xFFFE issues, then 3 lanes issue -> issue_seq=0xFFFE,0xFFFF,0x0000; seq_next=0x0001.
- Load to r5 issued, then flush (or rst_n=0) the next cycle -> lane reading r5 issues immediately in the following cycle; during flush, issue=stall=0.
